// File: rtl/rename_regfile.sv
// rename_regfile: architectural register file with rename tags for the
// Tomasulo/ROB core. Each register holds its committed value, a busy bit and
// the tag of the ROB entry that will produce its next value. Issue returns the
// registered operand status of rs1/rs2 and renames rd; commit writes the value
// back and frees the register only if no newer producer has renamed it since;
// flush drops every speculative mapping.
//
// Build option: define RF_COMMIT_BYPASS_EN to forward a same-cycle matching
// commit straight into the issue operand lookup. When it is undefined, such an
// operand is reported as waiting on the committing tag, and the ROB picks the
// value up from its own commit broadcast.
module rename_regfile #(
  parameter int REG_NUM   = 32,
  parameter int REG_ADD_W = 5,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 iIS_En,
  input  logic [REG_ADD_W-1:0] iIS_Rs1,
  input  logic [REG_ADD_W-1:0] iIS_Rs2,
  input  logic                 iIS_EnRd,
  input  logic [REG_ADD_W-1:0] iIS_Rd,
  input  logic [TAG_W-1:0]     iROB_Qn,
  input  logic                 iROB_En,
  input  logic [REG_ADD_W-1:0] iROB_Rd,
  input  logic [TAG_W-1:0]     iROB_Tag,
  input  logic [DATA_W-1:0]    iROB_Vd,
  input  logic                 iROB_Flush,
  output logic                 oROB_En,
  output logic                 oROB_Rdy1,
  output logic [TAG_W-1:0]     oROB_Qs1,
  output logic [DATA_W-1:0]    oROB_Vs1,
  output logic                 oROB_Rdy2,
  output logic [TAG_W-1:0]     oROB_Qs2,
  output logic [DATA_W-1:0]    oROB_Vs2
);

  localparam int OP_W = 1 + TAG_W + DATA_W;

  // Register 0 is never written, so it always reads value 0 and not busy.
  logic [DATA_W-1:0]  v   [REG_NUM];
  logic [TAG_W-1:0]   tag [REG_NUM];
  logic [REG_NUM-1:0] busy;

  logic            issue_ok;
  logic            commit_ok;
  logic            rename_ok;
  logic [OP_W-1:0] op1;
  logic [OP_W-1:0] op2;

  assign issue_ok  = iIS_En && !iROB_Flush;
  assign commit_ok = iROB_En && (iROB_Rd != '0);
  assign rename_ok = issue_ok && iIS_EnRd && (iIS_Rd != '0);

  // Operand status {rdy, tag, value} from pre-issue state; the tag is forced
  // to 0 when the operand is ready so the ROB never sees a stale producer.
  function automatic logic [OP_W-1:0] lookup(input logic [REG_ADD_W-1:0] rs);
    logic             rdy;
    logic [TAG_W-1:0] q;
    logic [DATA_W-1:0] val;
    rdy = !busy[rs];
    q   = busy[rs] ? tag[rs] : '0;
    val = v[rs];
`ifdef RF_COMMIT_BYPASS_EN
    if (commit_ok && (iROB_Rd == rs) && busy[rs] && (tag[rs] == iROB_Tag)) begin
      rdy = 1'b1;
      q   = '0;
      val = iROB_Vd;
    end
`endif
    return {rdy, q, val};
  endfunction

  // Combinational operand lookup for both sources.
  always_comb begin
    op1 = lookup(iIS_Rs1);
    op2 = lookup(iIS_Rs2);
  end

  // Registered issue response; payload holds between accepted issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oROB_En   <= 1'b0;
      oROB_Rdy1 <= 1'b0;
      oROB_Qs1  <= '0;
      oROB_Vs1  <= '0;
      oROB_Rdy2 <= 1'b0;
      oROB_Qs2  <= '0;
      oROB_Vs2  <= '0;
    end else if (en) begin
      oROB_En <= issue_ok;
      if (issue_ok) begin
        {oROB_Rdy1, oROB_Qs1, oROB_Vs1} <= op1;
        {oROB_Rdy2, oROB_Qs2, oROB_Vs2} <= op2;
      end
    end
  end

  // Register state: commit first, then rename (a same-cycle rename of the
  // committing register must win), then flush clears every busy bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        v[i]   <= '0;
        tag[i] <= '0;
      end
      busy <= '0;
    end else if (en) begin
      if (commit_ok) begin
        v[iROB_Rd] <= iROB_Vd;
        if (busy[iROB_Rd] && (tag[iROB_Rd] == iROB_Tag))
          busy[iROB_Rd] <= 1'b0;
      end
      if (rename_ok) begin
        busy[iIS_Rd] <= 1'b1;
        tag[iIS_Rd]  <= iROB_Qn;
      end
      if (iROB_Flush)
        busy <= '0;
    end
  end

endmodule

// File: tb/tb_rename_regfile.sv
// Scoreboard bench for rename_regfile: each accepted issue pushes its
// hand-computed operand status; a monitor pops and compares on every new
// oROB_En. Direct checks cover reset, flush and enable-hold behaviour.
module tb_rename_regfile;

  localparam int EW = 74;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic        iIS_En = 1'b0;
  logic [4:0]  iIS_Rs1 = '0, iIS_Rs2 = '0, iIS_Rd = '0;
  logic        iIS_EnRd = 1'b0;
  logic [3:0]  iROB_Qn = '0;
  logic        iROB_En = 1'b0;
  logic [4:0]  iROB_Rd = '0;
  logic [3:0]  iROB_Tag = '0;
  logic [31:0] iROB_Vd = '0;
  logic        iROB_Flush = 1'b0;
  logic        oROB_En, oROB_Rdy1, oROB_Rdy2;
  logic [3:0]  oROB_Qs1, oROB_Qs2;
  logic [31:0] oROB_Vs1, oROB_Vs2;

  int n_chk  = 0;
  int n_fail = 0;
  logic [EW-1:0] exp_q[$];
  logic en_q = 1'b0;

  rename_regfile dut (
    .clk(clk), .rst(rst), .en(en),
    .iIS_En(iIS_En), .iIS_Rs1(iIS_Rs1), .iIS_Rs2(iIS_Rs2),
    .iIS_EnRd(iIS_EnRd), .iIS_Rd(iIS_Rd), .iROB_Qn(iROB_Qn),
    .iROB_En(iROB_En), .iROB_Rd(iROB_Rd), .iROB_Tag(iROB_Tag),
    .iROB_Vd(iROB_Vd), .iROB_Flush(iROB_Flush),
    .oROB_En(oROB_En), .oROB_Rdy1(oROB_Rdy1), .oROB_Qs1(oROB_Qs1),
    .oROB_Vs1(oROB_Vs1), .oROB_Rdy2(oROB_Rdy2), .oROB_Qs2(oROB_Qs2),
    .oROB_Vs2(oROB_Vs2)
  );

  always #5 clk = ~clk;

  // en at the last edge tells the monitor whether outputs were refreshed.
  always @(posedge clk) en_q = en;

  always @(negedge clk) begin
    if (!rst && en_q && oROB_En) begin
      logic [EW-1:0] got, exp;
      got = {oROB_Rdy1, oROB_Qs1, oROB_Vs1, oROB_Rdy2, oROB_Qs2, oROB_Vs2};
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_issue_response got %h, none expected", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL operand_status got %h expected %h", got, exp);
        end
      end
    end
  end

  task automatic expect_op(input bit r1, input [3:0] q1, input [31:0] v1,
                           input bit r2, input [3:0] q2, input [31:0] v2);
    exp_q.push_back({r1, q1, v1, r2, q2, v2});
  endtask

  task automatic check(input string name, input logic [EW:0] got, input logic [EW:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, then return inputs to idle.
  task automatic step(input bit is_en, input [4:0] rs1, input [4:0] rs2,
                      input bit enrd, input [4:0] rd, input [3:0] qn,
                      input bit c_en, input [4:0] c_rd, input [3:0] c_tag,
                      input [31:0] c_vd, input bit flush);
    iIS_En = is_en; iIS_Rs1 = rs1; iIS_Rs2 = rs2; iIS_EnRd = enrd;
    iIS_Rd = rd; iROB_Qn = qn; iROB_En = c_en; iROB_Rd = c_rd;
    iROB_Tag = c_tag; iROB_Vd = c_vd; iROB_Flush = flush;
    @(posedge clk);
    #1;
    iIS_En = 0; iIS_EnRd = 0; iROB_En = 0; iROB_Flush = 0;
  endtask

  task automatic issue(input [4:0] rs1, input [4:0] rs2, input bit enrd,
                       input [4:0] rd, input [3:0] qn);
    step(1, rs1, rs2, enrd, rd, qn, 0, 0, 0, 0, 0);
  endtask

  task automatic commit(input [4:0] rd, input [3:0] t, input [31:0] vd);
    step(0, 0, 0, 0, 0, 0, 1, rd, t, vd, 0);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  logic [EW:0] all_out;
  assign all_out = {oROB_En, oROB_Rdy1, oROB_Qs1, oROB_Vs1, oROB_Rdy2, oROB_Qs2, oROB_Vs2};

  initial begin
    #2;
    check("reset_outputs", all_out, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: create nonzero held outputs, then async reset between edges
    expect_op(1, 0, 0, 1, 0, 0); issue(0, 0, 1, 5, 9);
    expect_op(0, 9, 0, 1, 0, 0); issue(5, 0, 0, 0, 0);
    idle();
    rst = 1'b1; #1;
    check("async_reset_outputs", all_out, '0);
    rst = 1'b0;
    expect_op(1, 0, 0, 1, 0, 0); issue(5, 6, 0, 0, 0);

    // 2: rename, wait on tag, commit, ready
    expect_op(1, 0, 0, 1, 0, 0);          issue(0, 0, 1, 3, 7);
    expect_op(0, 7, 0, 1, 0, 0);          issue(3, 0, 0, 0, 0);
    commit(3, 7, 32'hDEAD);
    expect_op(1, 0, 32'hDEAD, 1, 0, 0);   issue(3, 0, 0, 0, 0);

    // 3: stale commit must not free a newer mapping
    expect_op(1, 0, 0, 1, 0, 0);          issue(0, 0, 1, 4, 1);
    expect_op(1, 0, 0, 1, 0, 0);          issue(0, 0, 1, 4, 2);
    commit(4, 1, 32'h11);
    expect_op(0, 2, 32'h11, 1, 0, 0);     issue(4, 0, 0, 0, 0);
    commit(4, 2, 32'h22);
    expect_op(1, 0, 32'h22, 1, 0, 0);     issue(4, 0, 0, 0, 0);

    // 4: rs==rd reads old mapping; x0 ignores renames
    expect_op(1, 0, 0, 1, 0, 0);          issue(0, 0, 1, 8, 1);
    commit(8, 1, 32'h80);
    expect_op(1, 0, 32'h80, 1, 0, 32'hDEAD); issue(8, 3, 1, 8, 5);
    expect_op(0, 5, 32'h80, 1, 0, 0);     issue(8, 0, 0, 0, 0);
    expect_op(1, 0, 0, 1, 0, 0);          issue(0, 0, 1, 0, 3);
    expect_op(1, 0, 0, 1, 0, 0);          issue(0, 0, 0, 0, 0);

    // 5: flush drops issue, keeps commit value, clears busy
    expect_op(1, 0, 0, 1, 0, 0);          issue(0, 0, 1, 9, 8);
    expect_op(1, 0, 0, 1, 0, 0);          issue(0, 0, 1, 10, 9);
    step(1, 9, 0, 1, 11, 6, 1, 9, 8, 32'h99, 1);
    #2;
    check("flush_drops_issue", {73'd0, oROB_En}, {73'd0, 1'b0});
    expect_op(1, 0, 32'h99, 1, 0, 0);     issue(9, 10, 0, 0, 0);
    expect_op(1, 0, 0, 1, 0, 0);          issue(11, 10, 0, 0, 0);

    // 7: same-cycle rename and stale-freeing commit -> rename wins
    expect_op(1, 0, 0, 1, 0, 0);          issue(0, 0, 1, 13, 3);
    expect_op(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 13, 5, 1, 13, 3, 32'h55, 0);
    expect_op(0, 5, 32'h55, 1, 0, 0);     issue(13, 0, 0, 0, 0);

    // 6: issue with same-cycle matching commit
    expect_op(1, 0, 0, 1, 0, 0);          issue(0, 0, 1, 12, 4);
`ifdef RF_COMMIT_BYPASS_EN
    expect_op(1, 0, 32'h1234, 1, 0, 32'h22);
`else
    expect_op(0, 4, 32'h0, 1, 0, 32'h22);
`endif
    step(1, 12, 4, 0, 0, 0, 1, 12, 4, 32'h1234, 0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1, 3, 3, 1, 12, 9, 1, 12, 9, 32'hBAD, 0);
      #2;
`ifdef RF_COMMIT_BYPASS_EN
      check("enable_hold", all_out, {1'b1, 1'b1, 4'd0, 32'h1234, 1'b1, 4'd0, 32'h22});
`else
      check("enable_hold", all_out, {1'b1, 1'b0, 4'd4, 32'h0, 1'b1, 4'd0, 32'h22});
`endif
    end
    en = 1'b1;
    expect_op(1, 0, 32'h1234, 1, 0, 0);   issue(12, 0, 0, 0, 0);
    idle();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
